// File: rtl/riscv_pkg.sv
// Shared decode constants and the ID/EX control bundle for the 5-stage RISC-V pipeline.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_AW  = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       illegal;
  } idex_ctrl_t;

  // True when a 5-bit register index names an implemented register.
  function automatic logic idx_ok(logic [REG_AW-1:0] idx, int unsigned nregs);
    return (32'(idx) < nregs);
  endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// IF/ID, writeback and ID/EX signal bundle for the decode stage.
interface id_stage_hz_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic               in_valid;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    pc;
  logic               flush;
  logic               wb_we;
  logic [REG_AW-1:0]  wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               stall;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;
  logic [REG_AW-1:0]  ex_rd;
  logic [XLEN-1:0]    ex_rs1_data;
  logic [XLEN-1:0]    ex_rs2_data;
  logic [XLEN-1:0]    ex_imm;
  logic [2:0]         ex_alu_ctrl;
  logic               ex_alu_src;
  logic               ex_mem_write;
  logic               ex_reg_write;
  logic [1:0]         ex_result_src;
  logic               ex_branch;
  logic               ex_jump;
  logic               ex_illegal;

  modport master (
    output in_valid, instr, pc, flush, wb_we, wb_rd, wb_data,
    input  stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_alu_ctrl, ex_alu_src, ex_mem_write, ex_reg_write,
           ex_result_src, ex_branch, ex_jump, ex_illegal
  );

  modport slave (
    input  in_valid, instr, pc, flush, wb_we, wb_rd, wb_data,
    output stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_alu_ctrl, ex_alu_src, ex_mem_write, ex_reg_write,
           ex_result_src, ex_branch, ex_jump, ex_illegal
  );
endinterface

// File: rtl/regfile_mp.sv
// NREGS x XLEN register file, 2 combinational read ports, 1 write port.
// Optional WB_BYPASS_EN: a same-cycle write is forwarded to the read ports.
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1_data_c,
  output logic [XLEN-1:0]   rd2_data_c,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_ok_c;

  // x0 and out-of-range destinations are never written.
  assign wr_ok_c = we && (wa != '0) && idx_ok(wa, NREGS);

  // Next register contents.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok_c) begin
      regs_d[wa[AW-1:0]] = wd;
    end
  end

  // Register array, cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read ports; x0 and unimplemented indices read as zero.
  always_comb begin
    rd1_data_c = '0;
    rd2_data_c = '0;
    if ((ra1 != '0) && idx_ok(ra1, NREGS)) rd1_data_c = regs_q[ra1[AW-1:0]];
    if ((ra2 != '0) && idx_ok(ra2, NREGS)) rd2_data_c = regs_q[ra2[AW-1:0]];
`ifdef WB_BYPASS_EN
    if (wr_ok_c && (wa == ra1)) rd1_data_c = wd;
    if (wr_ok_c && (wa == ra2)) rd2_data_c = wd;
`endif
  end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage: decode, register read, immediate generation, load-use
// stall detection and the ID/EX pipeline register.
// Optional macro WB_BYPASS_EN enables write-first register reads.
module id_stage_hz
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic          clk,
  input  logic          reset,
  id_stage_hz_if.slave  bus
);

  logic [6:0]        opcode_c;
  logic [REG_AW-1:0] rd_c;
  logic [REG_AW-1:0] rs1_c;
  logic [REG_AW-1:0] rs2_c;
  logic [2:0]        funct3_c;
  logic [6:0]        funct7_c;

  idex_ctrl_t        dec_ctrl_c;
  logic [XLEN-1:0]   imm_c;
  logic              uses_rs1_c;
  logic              rs2_opcode_c;
  logic              load_use_c;
  logic [XLEN-1:0]   rs1_data_c;
  logic [XLEN-1:0]   rs2_data_c;

  logic              ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [REG_AW-1:0] ex_rs1_q,      ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,      ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
  idex_ctrl_t        ex_ctrl_q,     ex_ctrl_d;

  assign opcode_c = bus.instr[6:0];
  assign rd_c     = bus.instr[11:7];
  assign funct3_c = bus.instr[14:12];
  assign rs1_c    = bus.instr[19:15];
  assign rs2_c    = bus.instr[24:20];
  assign funct7_c = bus.instr[31:25];

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .ra1        (rs1_c),
    .ra2        (rs2_c),
    .rd1_data_c (rs1_data_c),
    .rd2_data_c (rs2_data_c),
    .we         (bus.wb_we),
    .wa         (bus.wb_rd),
    .wd         (bus.wb_data)
  );

  // Instruction decode and sign-extended immediate.
  always_comb begin
    dec_ctrl_c = '0;
    imm_c      = '0;
    uses_rs1_c = 1'b0;
    unique case (opcode_c)
      OP_LOAD: begin
        uses_rs1_c = 1'b1;
        imm_c      = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        if (funct3_c == 3'b010) begin
          dec_ctrl_c.alu_src    = 1'b1;
          dec_ctrl_c.result_src = RES_MEM;
          dec_ctrl_c.reg_write  = 1'b1;
        end else begin
          dec_ctrl_c.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        uses_rs1_c = 1'b1;
        imm_c      = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
        if (funct3_c == 3'b010) begin
          dec_ctrl_c.alu_src   = 1'b1;
          dec_ctrl_c.mem_write = 1'b1;
        end else begin
          dec_ctrl_c.illegal = 1'b1;
        end
      end
      OP_RTYPE: begin
        uses_rs1_c           = 1'b1;
        dec_ctrl_c.reg_write = 1'b1;
        if (funct7_c == 7'b0000000) begin
          unique case (funct3_c)
            3'b000:  dec_ctrl_c.alu_ctrl = ALU_ADD;
            3'b111:  dec_ctrl_c.alu_ctrl = ALU_AND;
            3'b110:  dec_ctrl_c.alu_ctrl = ALU_OR;
            3'b010:  dec_ctrl_c.alu_ctrl = ALU_SLT;
            default: dec_ctrl_c.illegal  = 1'b1;
          endcase
        end else if ((funct7_c == 7'b0100000) && (funct3_c == 3'b000)) begin
          dec_ctrl_c.alu_ctrl = ALU_SUB;
        end else begin
          dec_ctrl_c.illegal = 1'b1;
        end
      end
      OP_IALU: begin
        uses_rs1_c           = 1'b1;
        imm_c                = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        dec_ctrl_c.alu_src   = 1'b1;
        dec_ctrl_c.reg_write = 1'b1;
        unique case (funct3_c)
          3'b000:  dec_ctrl_c.alu_ctrl = ALU_ADD;
          3'b111:  dec_ctrl_c.alu_ctrl = ALU_AND;
          3'b110:  dec_ctrl_c.alu_ctrl = ALU_OR;
          3'b010:  dec_ctrl_c.alu_ctrl = ALU_SLT;
          default: dec_ctrl_c.illegal  = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        uses_rs1_c = 1'b1;
        imm_c      = {{(XLEN-12){bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                      bus.instr[11:8], 1'b0};
        if (funct3_c == 3'b000) begin
          dec_ctrl_c.alu_ctrl = ALU_SUB;
          dec_ctrl_c.branch   = 1'b1;
        end else begin
          dec_ctrl_c.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        imm_c                 = {{(XLEN-20){bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                                 bus.instr[30:21], 1'b0};
        dec_ctrl_c.result_src = RES_PC4;
        dec_ctrl_c.reg_write  = 1'b1;
        dec_ctrl_c.jump       = 1'b1;
      end
      default: dec_ctrl_c.illegal = 1'b1;
    endcase
    // Unimplemented register indices (RV32E) make the instruction illegal.
    if ((uses_rs1_c && !idx_ok(rs1_c, NREGS)) ||
        (rs2_opcode_c && !idx_ok(rs2_c, NREGS)) ||
        (dec_ctrl_c.reg_write && !idx_ok(rd_c, NREGS))) begin
      dec_ctrl_c.illegal = 1'b1;
    end
    // Illegal instructions carry no side-effecting controls.
    if (dec_ctrl_c.illegal) begin
      dec_ctrl_c         = '0;
      dec_ctrl_c.illegal = 1'b1;
      imm_c              = '0;
    end
  end

  assign rs2_opcode_c = (opcode_c == OP_RTYPE) || (opcode_c == OP_STORE) ||
                        (opcode_c == OP_BRANCH);

  // Load-use hazard against the load sitting in ID/EX; a flush suppresses it.
  assign load_use_c = ex_valid_q && (ex_ctrl_q.result_src == RES_MEM) &&
                      (ex_rd_q != '0) && bus.in_valid && !bus.flush &&
                      ((ex_rd_q == rs1_c) || (rs2_opcode_c && (ex_rd_q == rs2_c)));

  assign bus.stall = load_use_c;

  // Next ID/EX contents: bubble on flush, stall or empty IF/ID.
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_pc_d       = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_rd_d       = '0;
    ex_rs1_data_d = '0;
    ex_rs2_data_d = '0;
    ex_imm_d      = '0;
    ex_ctrl_d     = '0;
    if (!bus.flush && !load_use_c && bus.in_valid) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = bus.pc;
      ex_rs1_d      = rs1_c;
      ex_rs2_d      = rs2_c;
      ex_rd_d       = rd_c;
      ex_rs1_data_d = rs1_data_c;
      ex_rs2_data_d = rs2_data_c;
      ex_imm_d      = imm_c;
      ex_ctrl_d     = dec_ctrl_c;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_pc         = ex_pc_q;
  assign bus.ex_rs1        = ex_rs1_q;
  assign bus.ex_rs2        = ex_rs2_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_rs1_data   = ex_rs1_data_q;
  assign bus.ex_rs2_data   = ex_rs2_data_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_alu_ctrl   = ex_ctrl_q.alu_ctrl;
  assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
  assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
  assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
  assign bus.ex_result_src = ex_ctrl_q.result_src;
  assign bus.ex_branch     = ex_ctrl_q.branch;
  assign bus.ex_jump       = ex_ctrl_q.jump;
  assign bus.ex_illegal    = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: vector table with an expected-result queue,
// plus a hand-written reset-during-stall sequence.
module tb_id_stage_hz;
  import riscv_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [2:0]  alu;
    logic        asrc, mw, rw;
    logic [1:0]  rsrc;
    logic        br, jmp, ill;
  } ex_t;

  typedef struct {
    logic        iv;
    logic [31:0] instr, pc;
    logic        fl, we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        stall;
    ex_t         e;
  } vec_t;

`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP_X3 = 32'hDEAD;
`else
  localparam logic [31:0] BYP_X3 = 32'h0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  ex_t  sb[$];

  always #5 clk = ~clk;

  id_stage_hz_if #(.XLEN(32)) bus ();

  id_stage_hz #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic ex_t bub();
    return '0;
  endfunction

  function automatic ex_t okv(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] imm, logic [2:0] alu, logic asrc, logic mw,
                              logic rw, logic [1:0] rsrc, logic br, logic jmp);
    ex_t e;
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.d1 = d1; e.d2 = d2; e.imm = imm; e.alu = alu; e.asrc = asrc;
    e.mw = mw; e.rw = rw; e.rsrc = rsrc; e.br = br; e.jmp = jmp;
    return e;
  endfunction

  function automatic ex_t illv(logic [31:0] pc);
    ex_t e;
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.ill = 1'b1;
    return e;
  endfunction

  function automatic ex_t sample();
    ex_t g;
    g.valid = bus.ex_valid;     g.pc = bus.ex_pc;
    g.rs1 = bus.ex_rs1;         g.rs2 = bus.ex_rs2;        g.rd = bus.ex_rd;
    g.d1 = bus.ex_rs1_data;     g.d2 = bus.ex_rs2_data;    g.imm = bus.ex_imm;
    g.alu = bus.ex_alu_ctrl;    g.asrc = bus.ex_alu_src;   g.mw = bus.ex_mem_write;
    g.rw = bus.ex_reg_write;    g.rsrc = bus.ex_result_src;
    g.br = bus.ex_branch;       g.jmp = bus.ex_jump;       g.ill = bus.ex_illegal;
    return g;
  endfunction

  // Keep only the fields that are defined for this kind of expected result.
  function automatic ex_t keep(ex_t x, ex_t e);
    ex_t m;
    if (!e.valid) begin
      m = '0;
      m.valid = x.valid; m.alu = x.alu; m.asrc = x.asrc; m.mw = x.mw; m.rw = x.rw;
      m.rsrc = x.rsrc; m.br = x.br; m.jmp = x.jmp; m.ill = x.ill;
    end else if (e.ill) begin
      m = '0;
      m.valid = x.valid; m.mw = x.mw; m.rw = x.rw; m.br = x.br; m.jmp = x.jmp;
      m.ill = x.ill;
    end else begin
      m = x;
    end
    return m;
  endfunction

  task automatic chk(string name, logic [159:0] got, logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic av(logic iv, logic [31:0] instr, logic [31:0] pc, logic fl, logic we,
                    logic [4:0] wrd, logic [31:0] wd, logic st, ex_t e);
    vec_t v;
    v.iv = iv; v.instr = instr; v.pc = pc; v.fl = fl; v.we = we;
    v.wrd = wrd; v.wd = wd; v.stall = st; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(logic iv, logic [31:0] instr, logic [31:0] pc, logic fl, logic we,
                       logic [4:0] wrd, logic [31:0] wd);
    bus.in_valid = iv; bus.instr = instr; bus.pc = pc; bus.flush = fl;
    bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wd;
  endtask

  task automatic check_out(string name);
    ex_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s scoreboard empty got=0 exp=1", name);
    end else begin
      e = sb.pop_front();
      chk(name, 160'(keep(sample(), e)), 160'(keep(e, e)));
    end
  endtask

  initial begin
    // addi / preload / sw / lw-use / flush / bypass / x0 / ALU ops / illegal / more hazards
    av(1, 32'h00500093,  0, 0, 0, 0, 0,        0, okv( 0, 0, 5, 1,  0,  0, 5, ALU_ADD, 1, 0, 1, RES_ALU, 0, 0));
    av(0, 32'h0,         0, 0, 1, 1, 10,       0, bub());
    av(0, 32'h0,         0, 0, 1, 2, 20,       0, bub());
    av(1, 32'h0020a023,  4, 0, 0, 0, 0,        0, okv( 4, 1, 2, 0, 10, 20, 0, ALU_ADD, 1, 1, 0, RES_ALU, 0, 0));
    av(1, 32'h0000a283,  8, 0, 0, 0, 0,        0, okv( 8, 1, 0, 5, 10,  0, 0, ALU_ADD, 1, 0, 1, RES_MEM, 0, 0));
    av(1, 32'h00228333, 12, 0, 0, 0, 0,        1, bub());
    av(1, 32'h00228333, 12, 0, 0, 0, 0,        0, okv(12, 5, 2, 6,  0, 20, 0, ALU_ADD, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h0000a283, 16, 0, 0, 0, 0,        0, okv(16, 1, 0, 5, 10,  0, 0, ALU_ADD, 1, 0, 1, RES_MEM, 0, 0));
    av(1, 32'h00228463, 20, 1, 0, 0, 0,        0, bub());
    av(1, 32'h00228463, 20, 0, 0, 0, 0,        0, okv(20, 5, 2, 8,  0, 20, 8, ALU_SUB, 0, 0, 0, RES_ALU, 1, 0));
    av(1, 32'h00018233, 24, 0, 1, 3, 32'hDEAD, 0, okv(24, 3, 0, 4, BYP_X3, 0, 0, ALU_ADD, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h00018233, 28, 0, 0, 0, 0,        0, okv(28, 3, 0, 4, 32'hDEAD, 0, 0, ALU_ADD, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h00000233, 32, 0, 1, 0, 32'h1234, 0, okv(32, 0, 0, 4,  0,  0, 0, ALU_ADD, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h00000233, 36, 0, 0, 0, 0,        0, okv(36, 0, 0, 4,  0,  0, 0, ALU_ADD, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h40110433, 40, 0, 0, 0, 0,        0, okv(40, 2, 1, 8, 20, 10, 0, ALU_SUB, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'hFFF0A493, 44, 0, 0, 0, 0,        0, okv(44, 1, 31, 9, 10, 0, 32'hFFFFFFFF, ALU_SLT, 1, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h010000EF, 48, 0, 0, 0, 0,        0, okv(48, 0, 16, 1, 0,  0, 16, ALU_ADD, 0, 0, 1, RES_PC4, 0, 1));
    av(1, 32'h0000007F, 52, 0, 0, 0, 0,        0, illv(52));
    av(1, 32'h02000033, 56, 0, 0, 0, 0,        0, illv(56));
    av(0, 32'h00500093, 60, 0, 0, 0, 0,        0, bub());
    av(1, 32'h0000a283, 64, 0, 0, 0, 0,        0, okv(64, 1, 0, 5, 10,  0, 0, ALU_ADD, 1, 0, 1, RES_MEM, 0, 0));
    av(1, 32'h0050A023, 68, 0, 0, 0, 0,        1, bub());
    av(1, 32'h0050A023, 68, 0, 0, 0, 0,        0, okv(68, 1, 5, 0, 10,  0, 0, ALU_ADD, 1, 1, 0, RES_ALU, 0, 0));
    av(1, 32'h0000A003, 72, 0, 0, 0, 0,        0, okv(72, 1, 0, 0, 10,  0, 0, ALU_ADD, 1, 0, 1, RES_MEM, 0, 0));
    av(1, 32'h00200333, 76, 0, 0, 0, 0,        0, okv(76, 0, 2, 6,  0, 20, 0, ALU_ADD, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h0000a283, 80, 0, 0, 0, 0,        0, okv(80, 1, 0, 5, 10,  0, 0, ALU_ADD, 1, 0, 1, RES_MEM, 0, 0));
    av(1, 32'h00508313, 84, 0, 0, 0, 0,        0, okv(84, 1, 5, 6, 10,  0, 5, ALU_ADD, 1, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h0020E533, 88, 0, 0, 0, 0,        0, okv(88, 1, 2, 10, 10, 20, 0, ALU_OR, 0, 0, 1, RES_ALU, 0, 0));
    av(1, 32'h00F17593, 92, 0, 0, 0, 0,        0, okv(92, 2, 15, 11, 20, 0, 15, ALU_AND, 1, 0, 1, RES_ALU, 0, 0));

    // Reset state.
    reset = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_ex_valid", 160'(bus.ex_valid), 160'(0));
    chk("reset_stall", 160'(bus.stall), 160'(0));
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].fl, vecs[i].we, vecs[i].wrd, vecs[i].wd);
      sb.push_back(vecs[i].e);
      #1;
      chk($sformatf("stall_v%0d", i), 160'(bus.stall), 160'(vecs[i].stall));
      @(posedge clk);
      #1;
      check_out($sformatf("ex_v%0d", i));
    end

    // Reset asserted while a load-use stall is pending.
    @(negedge clk);
    drive(1, 32'h0000a283, 100, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 32'h00228333, 104, 0, 0, 0, 0);
    #1;
    chk("pre_reset_stall", 160'(bus.stall), 160'(1));
    reset = 1'b1;
    #1;
    chk("mid_reset_ex", 160'(sample()), 160'(bub()));
    chk("mid_reset_stall", 160'(bus.stall), 160'(0));
    @(posedge clk);
    #1;
    chk("held_reset_ex_valid", 160'(bus.ex_valid), 160'(0));
    @(negedge clk);
    reset = 1'b0;
    drive(1, 32'h00008233, 108, 0, 0, 0, 0);
    sb.push_back(okv(108, 1, 0, 4, 0, 0, 0, ALU_ADD, 0, 0, 1, RES_ALU, 0, 0));
    #1;
    chk("post_reset_stall", 160'(bus.stall), 160'(0));
    @(posedge clk);
    #1;
    check_out("post_reset_x1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
